eth_rx_frame_buf: RTL and testbench

ETH_RX_FRAME_BUF -- requirements
Module: eth_rx_frame_buf

---
 rtl/eth_rx_frame_buf.sv | 149 ++++++++++++++
 tb/tb_eth_rx_frame_buf.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_frame_buf.sv
// Ethernet receive frame buffer: stores incoming bytes speculatively and releases a frame to the output only once it is known to be good.
// Latency: out_vld rises 2 cycles after the in_last cycle of a good frame when the buffer was empty.
// Backpressure: none toward the receiver. A frame that meets a full buffer is dropped. The output is held stable while out_rdy is low.
// Ports:
//   clk, resetn                       - clock, synchronous active-low reset
//   in_vld/in_last/in_crc_ok/in_data  - byte stream from the MAC receiver
//   out_vld/out_rdy/out_data/out_last - committed byte stream, valid/ready handshake
//   cnt_ok/cnt_crc/cnt_drop           - saturating per-frame outcome counters
module eth_rx_frame_buf #(
    parameter int AW      = 11,
    parameter int MIN_LEN = 64
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_vld,
    input  logic       in_last,
    input  logic       in_crc_ok,
    input  logic [7:0] in_data,
    output logic       out_vld,
    input  logic       out_rdy,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic [7:0] cnt_ok,
    output logic [7:0] cnt_crc,
    output logic [7:0] cnt_drop
);
    localparam int          DEPTH   = 1 << AW;
    localparam logic [AW:0] DEPTH_P = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    // Each entry is {last, data}.
    logic [8:0]  mem_q [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] commit_ptr_q, commit_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [15:0] len_q, len_d, len_inc;
    logic        ovf_q, ovf_d;
    logic        out_vld_q, out_vld_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic [7:0]  cnt_ok_q, cnt_ok_d;
    logic [7:0]  cnt_crc_q, cnt_crc_d;
    logic [7:0]  cnt_drop_q, cnt_drop_d;

    logic full, ovf_now, wr_en, frame_end;
    logic is_drop, is_crc, is_ok, avail, rd_en;

    // A byte that arrives into a full buffer poisons the rest of its frame, including the last byte itself.
    assign full      = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
    assign ovf_now   = ovf_q | full;
    assign wr_en     = in_vld & ~ovf_now;
    assign frame_end = in_vld & in_last;
    assign len_inc   = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
    assign is_drop   = frame_end & (ovf_now | (len_inc < 16'(MIN_LEN)));
    assign is_crc    = frame_end & ~is_drop & ~in_crc_ok;
    assign is_ok     = frame_end & ~is_drop & in_crc_ok;

    // Only the committed region is visible to the reader. The single output register refills whenever it is empty or being drained.
    assign avail = rd_ptr_q != commit_ptr_q;
    assign rd_en = avail & (~out_vld_q | out_rdy);

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        len_d        = len_q;
        ovf_d        = ovf_q;
        out_vld_d    = out_vld_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        cnt_ok_d     = cnt_ok_q;
        cnt_crc_d    = cnt_crc_q;
        cnt_drop_d   = cnt_drop_q;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (in_vld) begin
            len_d = len_inc;
            ovf_d = ovf_now;
        end
        if (frame_end) begin
            len_d = 16'd0;
            ovf_d = 1'b0;
        end
        // An ok frame always writes its last byte, so the commit point lands just past it.
        if (is_ok) begin
            commit_ptr_d = wr_ptr_q + PTR_ONE;
            if (cnt_ok_q != 8'hFF) cnt_ok_d = cnt_ok_q + 8'd1;
        end
        if (is_drop || is_crc) begin
            wr_ptr_d = commit_ptr_q;
        end
        if (is_drop && cnt_drop_q != 8'hFF) cnt_drop_d = cnt_drop_q + 8'd1;
        if (is_crc && cnt_crc_q != 8'hFF) cnt_crc_d = cnt_crc_q + 8'd1;

        if (rd_en) begin
            rd_ptr_d   = rd_ptr_q + PTR_ONE;
            out_vld_d  = 1'b1;
            out_data_d = mem_q[rd_ptr_q[AW-1:0]][7:0];
            out_last_d = mem_q[rd_ptr_q[AW-1:0]][8];
        end else if (out_rdy) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            out_vld_q    <= 1'b0;
            out_data_q   <= 8'h00;
            out_last_q   <= 1'b0;
            cnt_ok_q     <= 8'h00;
            cnt_crc_q    <= 8'h00;
            cnt_drop_q   <= 8'h00;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            len_q        <= len_d;
            ovf_q        <= ovf_d;
            out_vld_q    <= out_vld_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            cnt_ok_q     <= cnt_ok_d;
            cnt_crc_q    <= cnt_crc_d;
            cnt_drop_q   <= cnt_drop_d;
        end
    end

    // The storage array needs no reset. Pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (resetn && wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_last = out_last_q;
    assign cnt_ok   = cnt_ok_q;
    assign cnt_crc  = cnt_crc_q;
    assign cnt_drop = cnt_drop_q;
endmodule

// File: tb/tb_eth_rx_frame_buf.sv
// Bench for eth_rx_frame_buf. It drives a default-size instance and a 64-entry instance from the same receive stream.
// Expected bytes go into per-instance queues at stimulus time. Negedge monitors pop and compare them on each output handshake.
module tb_eth_rx_frame_buf;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       in_vld = 1'b0, in_last = 1'b0, in_crc_ok = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_rdy = 1'b0, out_rdy_s = 1'b0;
    logic       out_vld, out_last, out_vld_s, out_last_s;
    logic [7:0] out_data, out_data_s;
    logic [7:0] cnt_ok, cnt_crc, cnt_drop, cnt_ok_s, cnt_crc_s, cnt_drop_s;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] q[$];
    logic [8:0] q_s[$];
    bit         rdy_rand = 1'b0;
    bit         hold_pend = 1'b0;
    logic [8:0] hold_val = '0;

    always #5 clk = ~clk;

    eth_rx_frame_buf #(.AW(11), .MIN_LEN(64)) dut (
        .clk(clk), .resetn(resetn), .in_vld(in_vld), .in_last(in_last),
        .in_crc_ok(in_crc_ok), .in_data(in_data), .out_vld(out_vld),
        .out_rdy(out_rdy), .out_data(out_data), .out_last(out_last),
        .cnt_ok(cnt_ok), .cnt_crc(cnt_crc), .cnt_drop(cnt_drop)
    );

    eth_rx_frame_buf #(.AW(6), .MIN_LEN(64)) dut_s (
        .clk(clk), .resetn(resetn), .in_vld(in_vld), .in_last(in_last),
        .in_crc_ok(in_crc_ok), .in_data(in_data), .out_vld(out_vld_s),
        .out_rdy(out_rdy_s), .out_data(out_data_s), .out_last(out_last_s),
        .cnt_ok(cnt_ok_s), .cnt_crc(cnt_crc_s), .cnt_drop(cnt_drop_s)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor for the default instance: byte order and content, plus output stability during a stall.
    always @(negedge clk) begin
        if (!resetn) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) chk("stall_hold", {out_vld, out_last, out_data}, {1'b1, hold_val});
            hold_pend = out_vld & ~out_rdy;
            hold_val  = {out_last, out_data};
            if (out_vld && out_rdy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected no output", {out_last, out_data});
                end else begin
                    chk("out_byte", {out_last, out_data}, q.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && out_vld_s && out_rdy_s) begin
            if (q_s.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte_s: got 0x%0h, expected no output", {out_last_s, out_data_s});
            end else begin
                chk("out_byte_s", {out_last_s, out_data_s}, q_s.pop_front());
            end
        end
    end

    task automatic drive_byte(input logic [7:0] d, input logic last, input logic crc);
        @(posedge clk);
        #1;
        in_vld = 1'b1; in_data = d; in_last = last; in_crc_ok = crc;
        if (rdy_rand) out_rdy = 1'($urandom_range(0, 1));
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_vld = 1'b0; in_last = 1'b0; in_crc_ok = 1'b0;
            if (rdy_rand) out_rdy = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic send_frame(input int len, input int base, input logic crc,
                              input bit push_m, input bit push_s);
        logic [7:0] d;
        logic       l;
        for (int i = 0; i < len; i++) begin
            d = 8'(base + i);
            l = (i == len - 1);
            if (push_m) q.push_back({l, d});
            if (push_s) q_s.push_back({l, d});
            drive_byte(d, l, crc);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        resetn = 1'b0; in_vld = 1'b0; in_last = 1'b0; in_crc_ok = 1'b0;
        q.delete();
        q_s.delete();
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            if (q.size() == 0 && q_s.size() == 0) break;
            cyc(1);
        end
        checks++;
        if (q.size() != 0 || q_s.size() != 0) begin
            errors++;
            $display("FAIL %s: got %0d/%0d bytes still pending, expected 0", name, q.size(), q_s.size());
        end
        cyc(3);
    endtask

    initial begin
        int run;
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_cnt_ok", cnt_ok, 0);
        chk("rst_cnt_crc", cnt_crc, 0);
        chk("rst_cnt_drop", cnt_drop, 0);

        // Good 64-byte frame: latency, sustained throughput, counters
        out_rdy = 1'b1;
        for (int i = 0; i < 63; i++) begin
            q.push_back({1'b0, 8'(i)});
            drive_byte(8'(i), 1'b0, 1'b1);
        end
        q.push_back({1'b1, 8'h3F});
        drive_byte(8'h3F, 1'b1, 1'b1);
        @(negedge clk);
        chk("lat_in_last_cycle", out_vld, 0);
        @(posedge clk);
        #1;
        in_vld = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("lat_plus1", out_vld, 0);
        @(negedge clk);
        chk("lat_plus2", out_vld, 1);
        run = 1;
        repeat (63) begin
            @(negedge clk);
            if (out_vld) run++;
        end
        chk("throughput", run, 64);
        @(negedge clk);
        chk("idle_after_frame", out_vld, 0);
        wait_drain("drain_t1", 200);
        chk("t1_cnt_ok", cnt_ok, 1);
        chk("t1_cnt_crc", cnt_crc, 0);
        chk("t1_cnt_drop", cnt_drop, 0);

        // Bad-CRC frame followed back-to-back by a good 70-byte frame
        do_reset();
        send_frame(64, 8'h80, 1'b0, 1'b0, 1'b0);
        send_frame(70, 8'h10, 1'b1, 1'b1, 1'b0);
        cyc(1);
        wait_drain("drain_t2", 300);
        chk("t2_cnt_crc", cnt_crc, 1);
        chk("t2_cnt_ok", cnt_ok, 1);
        chk("t2_cnt_drop", cnt_drop, 0);

        // Runt frames: 40 bytes, 63 bytes, and 50 bytes with bad CRC. The runt rule outranks the CRC check.
        do_reset();
        send_frame(40, 8'h20, 1'b1, 1'b0, 1'b0);
        cyc(5);
        chk("t3_cnt_drop_40", cnt_drop, 1);
        send_frame(63, 8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(50, 8'h00, 1'b0, 1'b0, 1'b0);
        cyc(10);
        chk("t3_cnt_drop", cnt_drop, 3);
        chk("t3_cnt_ok", cnt_ok, 0);
        chk("t3_cnt_crc", cnt_crc, 0);

        // Small buffer stalled: second frame overflows and is dropped, first frame survives
        do_reset();
        out_rdy = 1'b1;
        out_rdy_s = 1'b0;
        send_frame(64, 8'h40, 1'b1, 1'b1, 1'b1);
        send_frame(80, 8'hA0, 1'b1, 1'b1, 1'b0);
        cyc(5);
        chk("t4_s_cnt_drop", cnt_drop_s, 1);
        chk("t4_s_cnt_ok", cnt_ok_s, 1);
        chk("t4_s_out_vld_stalled", out_vld_s, 1);
        out_rdy_s = 1'b1;
        wait_drain("drain_t4", 400);
        chk("t4_s_out_vld_empty", out_vld_s, 0);
        chk("t4_cnt_ok", cnt_ok, 2);

        // 300 good frames with random 50% out_rdy: pointers wrap and cnt_ok saturates
        do_reset();
        out_rdy_s = 1'b0;
        rdy_rand = 1'b1;
        for (int f = 0; f < 300; f++) begin
            send_frame(64, f, 1'b1, 1'b1, 1'b0);
            cyc(100);
        end
        rdy_rand = 1'b0;
        out_rdy = 1'b1;
        wait_drain("drain_t5", 20000);
        chk("t5_cnt_ok_sat", cnt_ok, 8'hFF);
        chk("t5_cnt_crc", cnt_crc, 0);
        chk("t5_cnt_drop", cnt_drop, 0);

        // Reset mid-readout and mid-frame
        do_reset();
        out_rdy = 1'b0;
        send_frame(64, 8'h33, 1'b1, 1'b0, 1'b0);
        cyc(3);
        chk("t6_pre_cnt_ok", cnt_ok, 1);
        chk("t6_pre_out_vld", out_vld, 1);
        send_frame(10, 8'h00, 1'b0, 1'b0, 1'b0);
        do_reset();
        @(negedge clk);
        chk("t6_out_vld", out_vld, 0);
        chk("t6_cnt_ok", cnt_ok, 0);
        chk("t6_cnt_crc", cnt_crc, 0);
        chk("t6_cnt_drop", cnt_drop, 0);
        out_rdy = 1'b1;
        cyc(4);
        chk("t6_no_stale_out", out_vld, 0);
        send_frame(64, 8'h55, 1'b1, 1'b1, 1'b0);
        cyc(1);
        wait_drain("drain_t6", 200);
        chk("t6_post_cnt_ok", cnt_ok, 1);
        chk("t6_post_cnt_drop", cnt_drop, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
